// File: rtl/systolic_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// systolic_ctrl_pkg
// Purpose : shared constants for the systolic array sequencer. Holds the FSM
//           state encodings and the state register width. systolic_ctrl
//           imports this package.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package systolic_ctrl_pkg;

    localparam int SC_STATE_W = 3;

    // The encodings are plain constants so that older tools and other blocks
    // that decode the state bits keep working.
    localparam logic [SC_STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [SC_STATE_W-1:0] ST_LOAD  = 3'd1;
    localparam logic [SC_STATE_W-1:0] ST_COMP  = 3'd2;
    localparam logic [SC_STATE_W-1:0] ST_DRAIN = 3'd3;
    localparam logic [SC_STATE_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// ---------------------------------------------------------------------------
// sc_skew_line
// Purpose : fixed-depth delay line for an enable bit and its data word. It is
//           used to skew activations into the array's left edge and to deskew
//           results from the bottom edge. DEPTH = 0 is a straight wire.
// Ports   : i_clk    clock
//           i_rst_n  asynchronous active-low reset (clears every stage)
//           i_en     enable into the line
//           i_data   data into the line
//           o_en     enable delayed by DEPTH cycles
//           o_data   data delayed by DEPTH cycles
// ---------------------------------------------------------------------------
module sc_skew_line #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_en,
    output logic [DATA_WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_wire
            // No storage at this depth, so clock and reset are not needed.
            logic w_unusedClkRst;
            assign w_unusedClkRst = i_clk ^ i_rst_n;
            assign o_en   = i_en;
            assign o_data = i_data;
        end else begin : g_shift
            logic [DEPTH-1:0]      r_en;
            logic [DATA_WIDTH-1:0] r_data [DEPTH];

            // Shift the enable and data together every cycle. A reset
            // flushes anything that is in flight.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_en <= '0;
                    for (int k = 0; k < DEPTH; k++) begin
                        r_data[k] <= '0;
                    end
                end else begin
                    r_en[0]   <= i_en;
                    r_data[0] <= i_data;
                    for (int k = 1; k < DEPTH; k++) begin
                        r_en[k]   <= r_en[k-1];
                        r_data[k] <= r_data[k-1];
                    end
                end
            end

            assign o_en   = r_en[DEPTH-1];
            assign o_data = r_data[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_ctrl
// Purpose : sequencer for a ROWS x COLS weight-stationary PE array. It loads
//           one weight row per accepted beat (bottom row first). It then
//           streams input vectors into the left edge in row-skewed form,
//           deskews the column results from the bottom edge, and pulses done.
// Ports   : SC_clk/SC_rst_n      clock, async active-low reset
//           cfg_start/num_vecs   start pulse (IDLE only), vector count
//           busy/done            run status, 1-cycle completion pulse
//           w_valid/ready/data   weight-row handshake
//           a_valid/ready/data   input-vector handshake
//           arr_en_up/data_up    weight load into the top PE row
//           arr_en_left/data_left activations into the left PE column
//           arr_res_en/res_data  results from the bottom PE row
//           res_valid/res_data   deskewed result vector
// Config  : define SC_PERF_CNT_EN to add perf_cycles and perf_stalls outputs.
// ---------------------------------------------------------------------------
module systolic_ctrl
    import systolic_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int CNT_W      = 8
) (
    input  logic                       SC_clk,
    input  logic                       SC_rst_n,
    input  logic                       cfg_start,
    input  logic [CNT_W-1:0]           cfg_num_vecs,
    output logic                       busy,
    output logic                       done,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [COLS*DATA_WIDTH-1:0] w_data,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [ROWS*DATA_WIDTH-1:0] a_data,
    output logic [COLS-1:0]            arr_en_up,
    output logic [COLS*DATA_WIDTH-1:0] arr_data_up,
    output logic [ROWS-1:0]            arr_en_left,
    output logic [ROWS*DATA_WIDTH-1:0] arr_data_left,
    input  logic [COLS-1:0]            arr_res_en,
    input  logic [COLS*DATA_WIDTH-1:0] arr_res_data,
    output logic                       res_valid,
    output logic [COLS*DATA_WIDTH-1:0] res_data
`ifdef SC_PERF_CNT_EN
    ,
    output logic [31:0]                perf_cycles,
    output logic [31:0]                perf_stalls
`endif
);

    localparam int DW = DATA_WIDTH;

    logic [SC_STATE_W-1:0] r_state;
    logic [SC_STATE_W-1:0] w_nextState;
    logic [CNT_W-1:0]      r_numVecs;
    logic [CNT_W-1:0]      r_wCnt;
    logic [CNT_W-1:0]      r_aCnt;
    logic [CNT_W-1:0]      r_resCnt;
    logic [CNT_W-1:0]      w_resCntNext;
    logic                  w_start;
    logic                  w_wAcc;
    logic                  w_aAcc;
    logic                  w_inWin;
    logic                  w_lastRow;
    logic                  w_lastVec;
    logic                  r_skEn;
    logic [ROWS*DW-1:0]    r_skData;
    logic [COLS-1:0]       r_enUp;
    logic [COLS*DW-1:0]    r_dataUp;
    logic [COLS-1:0]       w_resEnGated;
    logic [COLS-1:0]       w_deskEn;
    logic [COLS*DW-1:0]    w_deskData;

    assign w_start   = (r_state == ST_IDLE) && cfg_start;
    assign w_wAcc    = (r_state == ST_LOAD) && w_valid;
    assign w_aAcc    = (r_state == ST_COMP) && a_valid;
    assign w_inWin   = (r_state == ST_COMP) || (r_state == ST_DRAIN);
    assign w_lastRow = (r_wCnt == CNT_W'(ROWS - 1));
    assign w_lastVec = ((r_aCnt + CNT_W'(1)) == r_numVecs);

    // The drain exit compares against the count including this cycle's
    // result, so a result arriving on the exit cycle is not lost.
    assign w_resCntNext = r_resCnt + CNT_W'(res_valid);

    assign busy    = (r_state != ST_IDLE);
    assign done    = (r_state == ST_DONE);
    assign w_ready = (r_state == ST_LOAD);
    assign a_ready = (r_state == ST_COMP);

    // Results that show up outside the compute/drain window are dropped
    // before they reach the deskew lines.
    assign w_resEnGated = arr_res_en & {COLS{w_inWin}};

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:  if (cfg_start) w_nextState = ST_LOAD;
            ST_LOAD:  if (w_wAcc && w_lastRow)
                          w_nextState = (r_numVecs == '0) ? ST_DONE : ST_COMP;
            ST_COMP:  if (w_aAcc && w_lastVec) w_nextState = ST_DRAIN;
            ST_DRAIN: if (w_resCntNext == r_numVecs) w_nextState = ST_DONE;
            ST_DONE:  w_nextState = ST_IDLE;
            default:  w_nextState = ST_IDLE;
        endcase
    end

    // State, the latched vector count, and beat/result counters. Start
    // clears the counters, so later cfg_num_vecs changes are ignored.
    always_ff @(posedge SC_clk or negedge SC_rst_n) begin
        if (!SC_rst_n) begin
            r_state   <= ST_IDLE;
            r_numVecs <= '0;
            r_wCnt    <= '0;
            r_aCnt    <= '0;
            r_resCnt  <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_start) begin
                r_numVecs <= cfg_num_vecs;
                r_wCnt    <= '0;
                r_aCnt    <= '0;
                r_resCnt  <= '0;
            end else begin
                if (w_wAcc)    r_wCnt   <= r_wCnt + CNT_W'(1);
                if (w_aAcc)    r_aCnt   <= r_aCnt + CNT_W'(1);
                if (res_valid) r_resCnt <= w_resCntNext;
            end
        end
    end

    // Weight load: one registered store pulse to every column per accepted
    // row. The data holds between beats.
    always_ff @(posedge SC_clk or negedge SC_rst_n) begin
        if (!SC_rst_n) begin
            r_enUp   <= '0;
            r_dataUp <= '0;
        end else begin
            r_enUp <= w_wAcc ? '1 : '0;
            if (w_wAcc) r_dataUp <= w_data;
        end
    end

    // Activation capture stage. The accept flag is registered once here, and
    // row i then adds i more cycles in its skew line. A cycle without a
    // vector becomes a bubble in every row's slot.
    always_ff @(posedge SC_clk or negedge SC_rst_n) begin
        if (!SC_rst_n) begin
            r_skEn   <= 1'b0;
            r_skData <= '0;
        end else begin
            r_skEn <= w_aAcc;
            if (w_aAcc) r_skData <= a_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_skew
            sc_skew_line #(.DATA_WIDTH(DW), .DEPTH(gi)) u_skew (
                .i_clk   (SC_clk),
                .i_rst_n (SC_rst_n),
                .i_en    (r_skEn),
                .i_data  (r_skData[gi*DW +: DW]),
                .o_en    (arr_en_left[gi]),
                .o_data  (arr_data_left[gi*DW +: DW])
            );
        end

        // Column j leaves the array j cycles after column 0, so it waits
        // COLS-1-j cycles to line up with the last column.
        for (gi = 0; gi < COLS; gi++) begin : g_deskew
            sc_skew_line #(.DATA_WIDTH(DW), .DEPTH(COLS - 1 - gi)) u_deskew (
                .i_clk   (SC_clk),
                .i_rst_n (SC_rst_n),
                .i_en    (w_resEnGated[gi]),
                .i_data  (arr_res_data[gi*DW +: DW]),
                .o_en    (w_deskEn[gi]),
                .o_data  (w_deskData[gi*DW +: DW])
            );
        end

        // Only the last column's enable marks a result vector. The other
        // aligned enables are redundant copies.
        if (COLS > 1) begin : g_deskEnSink
            logic w_unusedDeskEn;
            assign w_unusedDeskEn = ^w_deskEn[COLS-2:0];
        end
    endgenerate

    assign arr_en_up   = r_enUp;
    assign arr_data_up = r_dataUp;
    assign res_valid   = w_deskEn[COLS-1];
    assign res_data    = w_deskData;

`ifdef SC_PERF_CNT_EN
    logic [31:0] r_perfCycles;
    logic [31:0] r_perfStalls;

    // Performance counters clear on start, count while busy, and hold
    // their values once the run returns to idle.
    always_ff @(posedge SC_clk or negedge SC_rst_n) begin
        if (!SC_rst_n) begin
            r_perfCycles <= '0;
            r_perfStalls <= '0;
        end else if (w_start) begin
            r_perfCycles <= '0;
            r_perfStalls <= '0;
        end else begin
            if (busy) r_perfCycles <= r_perfCycles + 32'd1;
            if ((r_state == ST_COMP) && !a_valid) r_perfStalls <= r_perfStalls + 32'd1;
        end
    end

    assign perf_cycles = r_perfCycles;
    assign perf_stalls = r_perfStalls;
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// ---------------------------------------------------------------------------
// tb_systolic_ctrl
// Purpose : self-checking bench for systolic_ctrl with a behavioural 4x4
//           weight-stationary MAC array wired to the array-side ports.
//           Expected results are hand-computed constants.
// Config  : with SC_PERF_CNT_EN defined, the perf ports are connected and
//           the stall count is also checked.
// ---------------------------------------------------------------------------
module tb_systolic_ctrl;

    localparam int DW    = 32;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CNT_W = 8;

    logic                 SC_clk = 1'b0;
    logic                 SC_rst_n = 1'b0;
    logic                 cfg_start = 1'b0;
    logic [CNT_W-1:0]     cfg_num_vecs = '0;
    logic                 busy, done;
    logic                 w_valid = 1'b0;
    logic                 w_ready;
    logic [COLS*DW-1:0]   w_data = '0;
    logic                 a_valid = 1'b0;
    logic                 a_ready;
    logic [ROWS*DW-1:0]   a_data = '0;
    logic [COLS-1:0]      arr_en_up;
    logic [COLS*DW-1:0]   arr_data_up;
    logic [ROWS-1:0]      arr_en_left;
    logic [ROWS*DW-1:0]   arr_data_left;
    logic [COLS-1:0]      arr_res_en;
    logic [COLS*DW-1:0]   arr_res_data;
    logic                 res_valid;
    logic [COLS*DW-1:0]   res_data;
`ifdef SC_PERF_CNT_EN
    logic [31:0]          perfCycles, perfStalls;
`endif

    int compCount = 0;
    int errCount  = 0;

    systolic_ctrl #(.DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .SC_clk        (SC_clk),
        .SC_rst_n      (SC_rst_n),
        .cfg_start     (cfg_start),
        .cfg_num_vecs  (cfg_num_vecs),
        .busy          (busy),
        .done          (done),
        .w_valid       (w_valid),
        .w_ready       (w_ready),
        .w_data        (w_data),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_data        (a_data),
        .arr_en_up     (arr_en_up),
        .arr_data_up   (arr_data_up),
        .arr_en_left   (arr_en_left),
        .arr_data_left (arr_data_left),
        .arr_res_en    (arr_res_en),
        .arr_res_data  (arr_res_data),
        .res_valid     (res_valid),
        .res_data      (res_data)
`ifdef SC_PERF_CNT_EN
        ,
        .perf_cycles   (perfCycles),
        .perf_stalls   (perfStalls)
`endif
    );

    always #5 SC_clk = ~SC_clk;

    // Behavioural PE grid. Weights shift down on each store pulse.
    // Activations move right one PE per cycle and partial sums move down one
    // PE per cycle.
    logic signed [DW-1:0] mW [ROWS][COLS];
    logic signed [DW-1:0] mA [ROWS][COLS];
    logic signed [DW-1:0] mP [ROWS][COLS];
    logic                 mE [ROWS][COLS];

    always @(posedge SC_clk or negedge SC_rst_n) begin : arrayModel
        if (!SC_rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    mW[i][j] <= '0;
                    mA[i][j] <= '0;
                    mP[i][j] <= '0;
                    mE[i][j] <= 1'b0;
                end
            end
        end else begin
            for (int j = 0; j < COLS; j++) begin
                if (arr_en_up[j]) begin
                    for (int r = ROWS - 1; r > 0; r--) mW[r][j] <= mW[r-1][j];
                    mW[0][j] <= arr_data_up[j*DW +: DW];
                end
            end
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    logic signed [DW-1:0] aIn;
                    logic signed [DW-1:0] pIn;
                    logic                 eIn;
                    if (j == 0) begin
                        aIn = arr_data_left[i*DW +: DW];
                        eIn = arr_en_left[i];
                    end else begin
                        aIn = mA[i][j-1];
                        eIn = mE[i][j-1];
                    end
                    if (i == 0) pIn = '0;
                    else        pIn = mP[i-1][j];
                    mA[i][j] <= aIn;
                    mE[i][j] <= eIn;
                    mP[i][j] <= eIn ? (pIn + aIn * mW[i][j]) : '0;
                end
            end
        end
    end

    genvar gj;
    generate
        for (gj = 0; gj < COLS; gj++) begin : g_resOut
            assign arr_res_en[gj]              = mE[ROWS-1][gj];
            assign arr_res_data[gj*DW +: DW]   = mP[ROWS-1][gj];
        end
    endgenerate

    // Observation of DUT outputs on the falling edge.
    int cyc = 0;
    int doneCnt = 0, doneCyc = -1, wAccCnt = 0, lastWAccCyc = -1;
    int aReadyCnt = 0, enUpCnt = 0, enLeftCnt = 0;
    logic [COLS-1:0]    enUpVal = '0;
    logic [COLS*DW-1:0] resQ [$];
    logic [COLS*DW-1:0] upQ [$];

    always @(posedge SC_clk) cyc <= cyc + 1;

    always @(negedge SC_clk) begin
        if (res_valid) resQ.push_back(res_data);
        if (done) begin
            doneCnt = doneCnt + 1;
            doneCyc = cyc;
        end
        if (w_valid && w_ready) begin
            wAccCnt = wAccCnt + 1;
            lastWAccCyc = cyc;
        end
        if (a_ready) aReadyCnt = aReadyCnt + 1;
        if (arr_en_up != '0) begin
            enUpCnt = enUpCnt + 1;
            enUpVal = arr_en_up;
            upQ.push_back(arr_data_up);
        end
        if (arr_en_left != '0) enLeftCnt = enLeftCnt + 1;
    end

    logic [COLS*DW-1:0] wRow [ROWS];

    function automatic logic [127:0] pack4(input int v0, input int v1, input int v2, input int v3);
        return {v3, v2, v1, v0};
    endfunction

    function automatic logic [127:0] getRes(input int idx);
        if (idx < resQ.size()) return resQ[idx];
        return '0;
    endfunction

    function automatic logic [127:0] getUp(input int idx);
        if (idx < upQ.size()) return upQ[idx];
        return '0;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setIdentity();
        for (int i = 0; i < ROWS; i++) begin
            wRow[i] = '0;
            wRow[i][i*DW +: DW] = 32'd1;
        end
    endtask

    task automatic startRun(input int n);
        cfg_start = 1'b1;
        cfg_num_vecs = CNT_W'(n);
        @(posedge SC_clk); #1;
        cfg_start = 1'b0;
        checkOutput("busy_after_start", busy, 1);
    endtask

    task automatic sendBeat(input logic [COLS*DW-1:0] data);
        bit accepted = 0;
        w_valid = 1'b1;
        w_data  = data;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge SC_clk);
            accepted = w_ready;
            @(posedge SC_clk); #1;
        end
        w_valid = 1'b0;
        checkOutput("w_accept", accepted, 1);
    endtask

    task automatic sendWeights(input int g0, input int g1, input int g2, input int g3);
        int gaps [4];
        gaps = '{g0, g1, g2, g3};
        for (int k = 0; k < ROWS; k++) begin
            repeat (gaps[k]) begin
                @(posedge SC_clk); #1;
            end
            sendBeat(wRow[ROWS-1-k]);
        end
    endtask

    task automatic applyStimulus(input logic [ROWS*DW-1:0] vec);
        bit accepted = 0;
        a_valid = 1'b1;
        a_data  = vec;
        for (int t = 0; t < 50 && !accepted; t++) begin
            @(negedge SC_clk);
            accepted = a_ready;
            @(posedge SC_clk); #1;
        end
        a_valid = 1'b0;
        checkOutput("a_accept", accepted, 1);
    endtask

    task automatic bubble(input int n);
        a_valid = 1'b0;
        repeat (n) begin
            @(posedge SC_clk); #1;
        end
    endtask

    task automatic waitDone(input int bound);
        bit seen = 0;
        for (int t = 0; t < bound && !seen; t++) begin
            @(negedge SC_clk);
            if (done) seen = 1;
        end
        checkOutput("done_seen", seen, 1);
        @(posedge SC_clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int resBase, doneBase, upBase, enUpBase, wBase, aBase, enLeftBase;

        $display("[TB] systolic_ctrl bench starting");
        repeat (3) @(posedge SC_clk);
        #1 SC_rst_n = 1'b1;

        // Reset state.
        @(negedge SC_clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_w_ready", w_ready, 0);
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_en_up", arr_en_up, 0);
        checkOutput("rst_en_left", arr_en_left, 0);
        checkOutput("rst_data_up", arr_data_up, 0);
        checkOutput("rst_data_left", arr_data_left, 0);
        checkOutput("rst_res_data", res_data, 0);
        @(posedge SC_clk); #1;

        // Identity weights with two vectors pass the vectors through.
        $display("[TB] identity pass-through");
        setIdentity();
        resBase = resQ.size(); doneBase = doneCnt;
        startRun(2);
        sendWeights(0, 0, 0, 0);
        applyStimulus(pack4(1, 2, 3, 4));
        applyStimulus(pack4(5, 6, 7, 8));
        waitDone(100);
        checkOutput("id_count", resQ.size() - resBase, 2);
        checkOutput("id_res0", getRes(resBase), pack4(1, 2, 3, 4));
        checkOutput("id_res1", getRes(resBase + 1), pack4(5, 6, 7, 8));
        checkOutput("id_done_once", doneCnt - doneBase, 1);
        checkOutput("id_busy_after", busy, 0);

        // Zero vectors: four weight beats, then straight to done.
        $display("[TB] zero vectors");
        wBase = wAccCnt; aBase = aReadyCnt; doneBase = doneCnt; enUpBase = enUpCnt;
        startRun(0);
        sendWeights(0, 0, 0, 0);
        waitDone(20);
        repeat (3) begin
            @(posedge SC_clk); #1;
        end
        checkOutput("nv0_w_beats", wAccCnt - wBase, 4);
        checkOutput("nv0_a_ready", aReadyCnt - aBase, 0);
        checkOutput("nv0_done_lat", doneCyc, lastWAccCyc + 1);
        checkOutput("nv0_done_once", doneCnt - doneBase, 1);
        checkOutput("nv0_en_up", enUpCnt - enUpBase, 4);

        // Mixed weights with bubbles between the three vectors.
        $display("[TB] bubbles");
        wRow[0] = pack4(1, 0, 0, 1);
        wRow[1] = pack4(0, 1, 0, 1);
        wRow[2] = pack4(0, 0, 1, 1);
        wRow[3] = pack4(1, 1, 1, 1);
        resBase = resQ.size(); doneBase = doneCnt;
        startRun(3);
        sendWeights(0, 0, 0, 0);
        applyStimulus(pack4(1, 2, 3, 4));
        bubble(1);
        applyStimulus(pack4(2, 0, 1, 3));
        bubble(1);
        applyStimulus(pack4(10, 20, 30, -1));
        waitDone(100);
        checkOutput("bub_count", resQ.size() - resBase, 3);
        checkOutput("bub_res0", getRes(resBase), pack4(5, 6, 7, 10));
        checkOutput("bub_res1", getRes(resBase + 1), pack4(5, 3, 4, 6));
        checkOutput("bub_res2", getRes(resBase + 2), pack4(9, 19, 29, 59));
        checkOutput("bub_done_once", doneCnt - doneBase, 1);
`ifdef SC_PERF_CNT_EN
        checkOutput("bub_perf_stalls", perfStalls, 2);
`endif

        // A start pulse in COMP and a changed count are both ignored.
        $display("[TB] start ignored while busy");
        setIdentity();
        resBase = resQ.size(); doneBase = doneCnt;
        startRun(2);
        sendWeights(0, 0, 0, 0);
        applyStimulus(pack4(11, 12, 13, 14));
        cfg_start = 1'b1;
        cfg_num_vecs = 8'd7;
        @(posedge SC_clk); #1;
        cfg_start = 1'b0;
        applyStimulus(pack4(21, 22, 23, 24));
        waitDone(100);
        repeat (5) begin
            @(posedge SC_clk); #1;
        end
        checkOutput("ign_count", resQ.size() - resBase, 2);
        checkOutput("ign_res0", getRes(resBase), pack4(11, 12, 13, 14));
        checkOutput("ign_res1", getRes(resBase + 1), pack4(21, 22, 23, 24));
        checkOutput("ign_done_once", doneCnt - doneBase, 1);
        checkOutput("ign_idle_busy", busy, 0);
        checkOutput("ign_idle_w_ready", w_ready, 0);

        // Gaps between weight beats on cycles 0, 3, 4 and 9.
        $display("[TB] weight gaps");
        resBase = resQ.size(); upBase = upQ.size(); enUpBase = enUpCnt;
        startRun(1);
        sendWeights(0, 2, 0, 4);
        applyStimulus(pack4(9, 8, 7, 6));
        waitDone(100);
        checkOutput("gap_en_up_cycles", enUpCnt - enUpBase, 4);
        checkOutput("gap_en_up_val", enUpVal, 4'hF);
        for (int k = 0; k < ROWS; k++) begin
            checkOutput($sformatf("gap_up_beat%0d", k), getUp(upBase + k), wRow[ROWS-1-k]);
        end
        checkOutput("gap_res", getRes(resBase), pack4(9, 8, 7, 6));

        // Reset after two accepts in a 5-vector run, then restart.
        $display("[TB] reset mid-compute");
        startRun(5);
        sendWeights(0, 0, 0, 0);
        applyStimulus(pack4(3, 3, 3, 3));
        applyStimulus(pack4(4, 4, 4, 4));
        #2;
        resBase = resQ.size(); doneBase = doneCnt; enLeftBase = enLeftCnt;
        SC_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_a_ready", a_ready, 0);
        checkOutput("mid_rst_en_left", arr_en_left, 0);
        checkOutput("mid_rst_data_left", arr_data_left, 0);
        checkOutput("mid_rst_res_valid", res_valid, 0);
        checkOutput("mid_rst_done", done, 0);
        repeat (2) @(posedge SC_clk);
        #1 SC_rst_n = 1'b1;
        repeat (10) begin
            @(posedge SC_clk); #1;
        end
        checkOutput("mid_rst_no_done", doneCnt - doneBase, 0);
        checkOutput("mid_rst_flushed", enLeftCnt - enLeftBase, 0);
        checkOutput("mid_rst_no_res", resQ.size() - resBase, 0);
        resBase = resQ.size(); doneBase = doneCnt;
        startRun(1);
        sendWeights(0, 0, 0, 0);
        applyStimulus(pack4(4, 3, 2, 1));
        waitDone(100);
        checkOutput("restart_res", getRes(resBase), pack4(4, 3, 2, 1));
        checkOutput("restart_count", resQ.size() - resBase, 1);
        checkOutput("restart_done_once", doneCnt - doneBase, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
